// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered bitwise logic unit (NOT/BUF/AND/OR/XOR/NAND/NOR/XNOR)
// behind a valid/ready handshake. One output register plus a one-entry skid
// register give full throughput with a registered in_ready.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid=1 keeps its payload stable until that edge.
// in_ready depends only on registered state, never on out_ready.
//
// Optional feature: define LOGIC_UNIT_STATS_EN to build the saturating
// op_count drain counter. Without it, op_count is tied to 0 and stat_clr is
// ignored.
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] op_count
);

  // Occupancy states: EMPTY (nothing held), ONE (OUT full), TWO (OUT+SKID full)
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] result;
  logic             in_ready_q;
  logic             accept;
  logic             drain;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != ST_EMPTY);
  assign y         = out_q;
  assign accept    = in_valid & in_ready_q;
  assign drain     = out_valid & out_ready;

  // Operation decode; the result is only captured on accept, so X on idle
  // inputs never reaches a register.
  always_comb begin
    result = '0;
    case (op)
      3'b000:  result = ~a;
      3'b001:  result = a;
      3'b010:  result = a & b;
      3'b011:  result = a | b;
      3'b100:  result = a ^ b;
      3'b101:  result = ~(a & b);
      3'b110:  result = ~(a | b);
      3'b111:  result = ~(a ^ b);
      default: result = '0;
    endcase
  end

  // Next occupancy state from accept/drain
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_ONE;
      ST_ONE: begin
        if (accept && !drain)      state_nxt = ST_TWO;
        else if (!accept && drain) state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (drain) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // State register; in_ready is registered from the next state so it never
  // combinationally depends on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_TWO);
    end
  end

  // Data path: OUT always holds the oldest result, SKID the younger one
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (accept) out_q <= result;
        ST_ONE: begin
          if (accept && drain) out_q  <= result;
          else if (accept)     skid_q <= result;
        end
        ST_TWO:   if (drain) out_q <= skid_q;
        default: ;
      endcase
    end
  end

`ifdef LOGIC_UNIT_STATS_EN
  logic [CNT_W-1:0] op_cnt_q;

  // Saturating drain counter; clear has priority over a simultaneous drain
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      op_cnt_q <= '0;
    end else if (drain && (op_cnt_q != {CNT_W{1'b1}})) begin
      op_cnt_q <= op_cnt_q + 1'b1;
    end
  end

  assign op_count = op_cnt_q;
`else
  logic unused_stat_clr;

  assign unused_stat_clr = stat_clr;
  assign op_count        = '0;
`endif

endmodule
